// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus hand-off controller in front of the UART
// transmit engine. A byte stays at the FIFO head (and counted) until the
// engine reports the end of its stop bit, so an aborted byte is re-sent.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  ovf_clr,
  input  logic                  tx_en,
  input  logic                  tx_ok,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  tx_busy
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {PTR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_START    = 2'd1,
    S_WAIT_OK  = 2'd2,
    S_WAIT_END = 2'd3
  } state_e;

  // Storage (contents are don't-care after reset, so no reset on the array)
  logic [7:0]       mem_q [0:DEPTH-1];

  // State registers and their next values
  state_e           state_q,    state_d;
  logic [PTR_W-1:0] wptr_q,     wptr_d;
  logic [PTR_W-1:0] rptr_q,     rptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_byte_q,  tx_byte_d;
  logic             overflow_q, overflow_d;

  // Decoded control
  logic             full_s;
  logic             empty_s;
  logic             wr_acc_s;
  logic             wr_drop_s;
  logic             load_s;
  logic             pop_s;

  // Write-side decode: flags come from the registered count only, and a
  // flush swallows any write presented in the same cycle.
  always_comb begin
    full_s    = (count_q == CNT_FULL);
    empty_s   = (count_q == CNT_ZERO);
    wr_acc_s  = wr_en & ~full_s & ~flush;
    wr_drop_s = wr_en &  full_s & ~flush;
  end

  // FSM next-state: flush and tx_en-low both force S_IDLE without a pop.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (!tx_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty_s) begin
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          state_d = S_WAIT_OK;
        end
        S_WAIT_OK: begin
          if (tx_ok) begin
            state_d = S_WAIT_END;
          end else begin
            state_d = S_WAIT_OK;
          end
        end
        S_WAIT_END: begin
          if (!tx_ok) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_END;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FSM outputs: load the head byte with a start pulse from S_IDLE, retire
  // it on the stop-bit falling edge seen in S_WAIT_END.
  always_comb begin
    load_s = 1'b0;
    pop_s  = 1'b0;
    if (flush || !tx_en) begin
      load_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          load_s = ~empty_s;
        end
        S_WAIT_END: begin
          pop_s = ~tx_ok;
        end
        default: begin
          load_s = 1'b0;
          pop_s  = 1'b0;
        end
      endcase
    end
    tx_start_d = load_s;
    if (load_s) begin
      tx_byte_d = mem_q[rptr_q];
    end else begin
      tx_byte_d = tx_byte_q;
    end
  end

  // Pointer, occupancy and sticky-overflow update; an overflowing write beats
  // a same-cycle clear, and flush leaves the overflow flag alone.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = PTR_ZERO;
      rptr_d  = PTR_ZERO;
      count_d = CNT_ZERO;
    end else begin
      if (wr_acc_s) begin
        wptr_d = wptr_q + PTR_W'(1'b1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_W'(1'b1);
      end else begin
        rptr_d = rptr_q;
      end
      count_d = count_q + CNT_W'(wr_acc_s) - CNT_W'(pop_s);
    end
    if (wr_drop_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wptr_q     <= PTR_ZERO;
      rptr_q     <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'hFF;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write port; only accepted writes touch the array
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_byte    = tx_byte_q;
  assign fifo_full  = full_s;
  assign fifo_empty = empty_s;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign tx_busy    = (state_q != S_IDLE);

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Upstream stage of the UART transmit engine: a byte FIFO plus a hand-off controller.
- Accepts bytes from the register/bus side and buffers them.
- Presents each byte to the transmit engine on its data input, with a one-cycle start pulse.
- Retires the byte only when the engine signals stop-bit completion (falling edge of tx_ok).
- Software can burst-write without polling tx_ok per byte.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries).

Ports:
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  synchronous active-low reset
- wr_en  input  1  push request, one byte per asserted cycle
- wr_data  input  8  byte to push
- flush  input  1  synchronous FIFO/controller clear
- ovf_clr  input  1  clears sticky overflow flag
- tx_en  input  1  transmitter enable (same signal fed to the tx engine)
- tx_ok  input  1  from tx engine; high while the stop bit is being sent
- tx_start  output  1  to tx engine start input; registered one-cycle pulse
- tx_byte  output  8  to tx engine data input; registered, stable while a byte is in flight
- fifo_full  output  1  count == DEPTH
- fifo_empty  output  1  count == 0
- fifo_count  output  DEPTH_LOG2+1  entries held, including the in-flight head byte
- overflow  output  1  sticky; set when a write is dropped
- tx_busy  output  1  controller not in S_IDLE

Behaviour:
- Reset (rst_n low at posedge):
  - wptr, rptr and count = 0.
  - State = S_IDLE.
  - tx_start = 0, tx_byte = 8'hFF, fifo_empty = 1, fifo_full = 0, overflow = 0, tx_busy = 0.
  - Memory contents are don't-care.
- Write:
  - If wr_en and !fifo_full (pre-edge value): mem[wptr] <= wr_data, wptr++ mod DEPTH.
  - If wr_en and fifo_full: byte dropped, overflow <= 1. A pop in the same cycle does not rescue the write.
- Overflow: cleared only by ovf_clr or reset. If ovf_clr and an overflowing write occur in the same cycle, the set wins.
- Count: +1 on accepted write, -1 on pop, unchanged when both occur in the same cycle. Flags are derived from the registered count.
- Pointers wrap modulo DEPTH; full/empty are decided by count only.
- FSM states: S_IDLE, S_START, S_WAIT_OK, S_WAIT_END.
  - S_IDLE: if tx_en and !fifo_empty, then tx_byte <= mem[rptr], tx_start <= 1, go to S_START.
  - S_START: tx_start <= 0, go to S_WAIT_OK. tx_start is therefore high for exactly one clk cycle.
  - S_WAIT_OK: stay until tx_ok == 1, then go to S_WAIT_END.
  - S_WAIT_END: stay until tx_ok == 0; then pop (rptr++, count--) and go to S_IDLE.
  - The next byte's tx_start can be issued at the earliest one cycle after the pop.
- tx_byte holds its value from load until the next load. It never changes while in S_START, S_WAIT_OK or S_WAIT_END.
- tx_en low in any state:
  - Next state = S_IDLE, tx_start <= 0, no pop.
  - The head byte is retained and re-sent in full once tx_en returns.
- flush:
  - Pointers and count <= 0, state <= S_IDLE, tx_start <= 0.
  - tx_byte and overflow are unchanged.
  - A write in the same cycle as flush is discarded.
  - A byte already handed to the engine completes on the line; the controller does not track it.
- Priority: rst_n > flush > tx_en-low abort > normal operation.
- Latency: a write accepted at edge E0 into an empty FIFO with idle controller and tx_en = 1 gives tx_start high in the cycle after E1. fifo_empty falls after E0.
- tx_busy = (state != S_IDLE), combinational decode of the state register.

Test Plan:
1. Reset, tx_en = 1, write 8'hA5 once:
   - tx_start pulses exactly 1 cycle, one cycle after the write edge, with tx_byte = 8'hA5.
   - fifo_count = 1 until the model's tx_ok falls, then 0 and fifo_empty = 1.
2. Burst 3 bytes 8'h01, 8'h02, 8'h03 back-to-back, engine model with tx_ok high for 16 clks per byte:
   - Three tx_start pulses in order, each after the previous tx_ok fall.
   - tx_byte is never changed mid-byte.
3. With tx_en = 0, write 17 bytes (DEPTH = 16):
   - fifo_full = 1 after 16 writes; 17th dropped; overflow = 1; no tx_start.
   - ovf_clr clears overflow while fifo_count stays 16.
4. Fill to 16 entries, then write while a pop occurs in the same cycle:
   - Write dropped, overflow = 1, fifo_count = 15.
   - Write + pop at count 5: count stays 5.
5. Drop tx_en in S_WAIT_OK, then re-enable:
   - Controller returns to S_IDLE, count unchanged.
   - The same byte is reissued with a new tx_start pulse.
6. Assert flush and rst_n low in the middle of a burst:
   - flush: count = 0, tx_busy = 0, tx_byte held, overflow held.
   - rst_n low: every output returns to its reset value on the next edge.
